fb_page_ctrl: RTL
=================

// Module: fb_page_ctrl
// PURPOSE
//  Double-buffered frame memory controller for the 8x8 RGB LED matrix.
//  Holds two pages of 64 pixels x 3 bits (R,G,B). A writer fills the back page; the row scanner reads the front page.
//  Page swaps happen only at a frame boundary, so the display never tears.
//  Sits between the pattern/loader logic and the row-scan FSM and replaces the scanner's private frame buffer.
// PARAMETERS
//  ROW_NUM        8   matrix rows (fixed at 8; a power of 2)
//  COL_NUM        8   matrix columns (fixed at 8; sets the read-word width = 3*COL_NUM)
//  CLEAR_ON_SWAP  1   1: zero the new back page after every swap; 0: keep its old contents
// PORTS
//  clk_i          in   1   system clock, 50 MHz
//  rst_n_i        in   1   synchronous reset, active low
//  wr_valid_i     in   1   writer has a pixel to write
//  wr_ready_o     out  1   controller can accept a pixel write
//  wr_addr_i      in   6   pixel address: [5:3] = row, [2:0] = column
//  wr_data_i      in   3   pixel colour: bit0 = R, bit1 = G, bit2 = B (1 = LED on)
//  swap_req_i     in   1   one-cycle pulse: back page is complete, request a swap
//  swap_busy_o    out  1   a swap is pending or a clear is in progress
//  swap_done_o    out  1   one-cycle pulse: swap (and any clear) finished
//  frame_sync_i   in   1   one-cycle pulse from the scanner at frame start (row wraps 7->0, blanking)
//  rd_en_i        in   1   scanner read strobe
//  rd_row_i       in   3   row to read
//  rd_data_o      out  24  {B[7:0], G[7:0], R[7:0]}; bit index = column; 1 = on
//  front_sel_o    out  1   index of the page currently being displayed
// BEHAVIOUR
//  Reset (rst_n_i sampled low at a clk_i edge):
//   - state = INIT_CLR, clr_cnt = 0, front_sel_o = 0, rd_data_o = 0
//   - wr_ready_o = 0, swap_busy_o = 1, swap_done_o = 0
//  States and transitions:
//   INIT_CLR : writes 0 to address clr_cnt in BOTH pages. Lasts 64 cycles (clr_cnt 0..63), then goes to WRITE.
//              swap_done_o is NOT pulsed on this exit.
//   WRITE    : wr_ready_o = 1 and swap_busy_o = 0.
//              A write happens when wr_valid_i && wr_ready_o: data is stored at page[~front_sel][wr_addr_i].
//              swap_req_i moves the FSM to PENDING on the next cycle.
//              A write that coincides with swap_req_i is still accepted.
//   PENDING  : wr_ready_o = 0, swap_busy_o = 1; writes are stalled.
//              On frame_sync_i, front_sel_o toggles at the next edge. Next state is CLR if CLEAR_ON_SWAP, else WRITE.
//              Without frame_sync_i the FSM waits indefinitely.
//   CLR      : wr_ready_o = 0. Writes 0 to the new back page at clr_cnt for 64 cycles, then goes to WRITE.
//  swap_done_o pulses for one cycle on the transition into WRITE from PENDING or CLR.
//  swap_req_i outside WRITE is ignored; it is not queued.
//  Read path:
//   - rd_en_i at cycle N loads rd_data_o at edge N+1 from page[front_sel_o as seen in cycle N]. Latency is 1 cycle.
//   - When rd_en_i = 0, rd_data_o holds its value.
//  frame_sync_i and rd_en_i in the same cycle: the read returns OLD front page data. The new page is visible from the next read.
//  frame_sync_i outside PENDING has no effect.
//  Write and read never target the same page at the same time, so there is no read/write collision.
//  clr_cnt is 6 bits and wraps 63->0 on exit.
//  Reset asserted mid-CLR or mid-PENDING: the FSM restarts in INIT_CLR. Any pending swap is dropped and front_sel_o returns to 0.
//  Memory: 2 pages x 64 x 3 bits, as registers or distributed RAM. Reads are synchronous.
// TESTING
//  T1 reset:
//   - rst_n_i low for 2 cycles, then high -> wr_ready_o = 0 for exactly 64 cycles, then 1.
//   - Reading rows 0..7 -> rd_data_o = 24'h000000. No swap_done_o pulse.
//  T2 basic swap:
//   - Write addr 6'd9 with data 3'b101; read row 1 -> 24'h000000 (write went to the back page).
//   - Pulse swap_req_i, then frame_sync_i at cycle N -> front_sel_o = 1 at N+1.
//   - Reading row 1 -> 24'h020002.
//  T3 stall:
//   - swap_req_i, then hold wr_valid_i = 1 for 1000 cycles with no frame_sync_i -> wr_ready_o = 0, swap_busy_o = 1, memory unchanged.
//  T4 clear (CLEAR_ON_SWAP = 1):
//   - After a swap, wr_ready_o = 0 for 64 cycles, then swap_done_o pulses once.
//   - Swap again with no writes -> every row reads 24'h000000.
//   - With CLEAR_ON_SWAP = 0, the old page contents reappear instead.
//  T5 coincident events:
//   - rd_en_i together with frame_sync_i in PENDING -> old page data; the next read returns new page data.
//   - wr_valid_i together with swap_req_i in WRITE -> the write is stored.
//  T6 reset mid-CLR:
//   - rst_n_i low at clear cycle 30 -> front_sel_o = 0, INIT_CLR runs the full 64 cycles, all rows read 0.

Source files
------------

// File: rtl/fb_page_ctrl.sv
// fb_page_ctrl: double-buffered 8x8 RGB frame memory for the LED matrix.
// The writer fills the back page, the scanner reads the front page, and swaps wait for frame_sync.
module fb_page_ctrl #(
    parameter int ROW_NUM       = 8,
    parameter int COL_NUM       = 8,
    parameter bit CLEAR_ON_SWAP = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [5:0]           wr_addr_i,
    input  logic [2:0]           wr_data_i,
    input  logic                 swap_req_i,
    output logic                 swap_busy_o,
    output logic                 swap_done_o,
    input  logic                 frame_sync_i,
    input  logic                 rd_en_i,
    input  logic [2:0]           rd_row_i,
    output logic [3*COL_NUM-1:0] rd_data_o,
    output logic                 front_sel_o
);

    localparam int PIX = ROW_NUM * COL_NUM;

    typedef enum logic [1:0] {
        INIT_CLR,
        WRITE,
        PENDING,
        CLR
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [5:0]           clr_cnt_q;
    logic                 last_clr;
    logic                 clr_en;
    logic                 swap_go;
    logic                 back_sel;
    logic [2:0]           mem_q [2][PIX];
    logic [2:0]           pix;
    logic [3*COL_NUM-1:0] rd_word;

    assign last_clr = (clr_cnt_q == 6'(PIX - 1));
    assign back_sel = ~front_sel_o;

    // State register plus the small control registers that move with it
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= INIT_CLR;
            clr_cnt_q   <= '0;
            front_sel_o <= 1'b0;
            swap_done_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_en ? clr_cnt_q + 6'd1 : 6'd0;
            if (swap_go) begin
                front_sel_o <= ~front_sel_o;
            end
            swap_done_o <= (state_d == WRITE) &&
                           ((state_q == PENDING) || (state_q == CLR));
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT_CLR: if (last_clr) state_d = WRITE;
            WRITE:    if (swap_req_i) state_d = PENDING;
            PENDING: begin
                if (frame_sync_i) begin
                    state_d = CLEAR_ON_SWAP ? CLR : WRITE;
                end
            end
            CLR:      if (last_clr) state_d = WRITE;
            default:  state_d = INIT_CLR;
        endcase
    end

    always_comb begin
        wr_ready_o  = 1'b0;
        swap_busy_o = 1'b1;
        clr_en      = 1'b0;
        swap_go     = 1'b0;
        unique case (state_q)
            INIT_CLR: clr_en = 1'b1;
            WRITE: begin
                wr_ready_o  = 1'b1;
                swap_busy_o = 1'b0;
            end
            PENDING:  swap_go = frame_sync_i;
            CLR:      clr_en = 1'b1;
            default:  clr_en = 1'b0;
        endcase
    end

    // The back page is never the one being scanned, so writes and reads never collide
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            if (state_q == INIT_CLR) begin
                mem_q[0][clr_cnt_q] <= '0;
                mem_q[1][clr_cnt_q] <= '0;
            end else if (state_q == CLR) begin
                mem_q[back_sel][clr_cnt_q] <= '0;
            end else if (wr_ready_o && wr_valid_i) begin
                mem_q[back_sel][wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        pix     = '0;
        for (int c = 0; c < COL_NUM; c++) begin
            pix                    = mem_q[front_sel_o][{rd_row_i, 3'(c)}];
            rd_word[c]             = pix[0];
            rd_word[COL_NUM+c]     = pix[1];
            rd_word[2*COL_NUM+c]   = pix[2];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= rd_word;
        end
    end

endmodule
